// File: rtl/snake_round_ctrl.sv
// Round sequencer for the two-player snake game: move timing, clear pulses and win/lose verdicts.
// Optional build macro SNAKE_SPEEDUP_EN shortens the move period every 16 moves.
module snake_round_ctrl #(
  parameter int TICK_DIV        = 25000000,
  parameter int TICK_W          = 25,
  parameter int CHECK_LAT       = 2,
  parameter int max_len_bit_len = 4,
  parameter int WIN_LEN         = 15,
  parameter int TICK_STEP       = 1000000,
  parameter int TICK_MIN        = 5000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       pause,
  input  logic                       should_stop1,
  input  logic                       should_stop2,
  input  logic [max_len_bit_len-1:0] len1,
  input  logic [max_len_bit_len-1:0] len2,
  output logic                       move_en,
  output logic                       clr,
  output logic                       running,
  output logic                       game_over,
  output logic [1:0]                 winner,
  output logic [15:0]                move_cnt,
  output logic [TICK_W-1:0]          tick_period
);

  localparam int CW = (CHECK_LAT > 1) ? $clog2(CHECK_LAT) : 1;
  localparam logic [CW-1:0] LAST_CHK = CW'(CHECK_LAT - 1);
  localparam logic [TICK_W-1:0] PERIOD_INIT = TICK_W'(TICK_DIV);
  localparam logic [max_len_bit_len-1:0] WIN_L = max_len_bit_len'(WIN_LEN);

  // Reject parameter sets that would make the timer or length compare meaningless.
  if (TICK_DIV < 2 || CHECK_LAT < 1 || WIN_LEN >= (1 << max_len_bit_len) ||
      TICK_DIV >= (1 << TICK_W) || TICK_MIN < 2 || TICK_STEP >= (1 << TICK_W)) begin : g_bad_params
    $error("snake_round_ctrl: illegal parameter combination");
  end

  typedef enum logic [2:0] {IDLE, CLEAR, RUN_WAIT, MOVE, CHECK, EVAL, OVER} state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [TICK_W-1:0]   period_q, period_d;
  logic [CW-1:0]       chk_cnt_q, chk_cnt_d;
  logic [15:0]         move_cnt_q, move_cnt_d;
  logic [1:0]          winner_q, winner_d;
  logic [1:0]          verdict;

`ifdef SNAKE_SPEEDUP_EN
  // Widened compare so the decrement can never wrap below the floor.
  localparam logic [TICK_W:0] FLOOR_GAP = (TICK_W+1)'(TICK_MIN) + (TICK_W+1)'(TICK_STEP);
  logic [TICK_W-1:0] period_dec;
  assign period_dec = ({1'b0, period_q} >= FLOOR_GAP) ? period_q - TICK_W'(TICK_STEP)
                                                      : TICK_W'(TICK_MIN);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      period_q   <= PERIOD_INIT;
      chk_cnt_q  <= '0;
      move_cnt_q <= '0;
      winner_q   <= 2'b00;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      period_q   <= period_d;
      chk_cnt_q  <= chk_cnt_d;
      move_cnt_q <= move_cnt_d;
      winner_q   <= winner_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    period_d   = period_q;
    chk_cnt_d  = chk_cnt_q;
    move_cnt_d = move_cnt_q;
    winner_d   = winner_q;
    verdict    = 2'b00;

    // Collisions outrank length wins; winner bits are {snake2, snake1}.
    if (should_stop1 && should_stop2)           verdict = 2'b11;
    else if (should_stop1)                      verdict = 2'b10;
    else if (should_stop2)                      verdict = 2'b01;
    else if (len1 >= WIN_L && len2 >= WIN_L)    verdict = 2'b11;
    else if (len1 >= WIN_L)                     verdict = 2'b01;
    else if (len2 >= WIN_L)                     verdict = 2'b10;

    case (state_q)
      IDLE, OVER: begin
        if (start) state_d = CLEAR;
      end
      CLEAR: begin
        tick_cnt_d = '0;
        move_cnt_d = '0;
        winner_d   = 2'b00;
        period_d   = PERIOD_INIT;
        state_d    = RUN_WAIT;
      end
      RUN_WAIT: begin
        if (!pause) begin
          if (tick_cnt_q == period_q - 1'b1) begin
            tick_cnt_d = '0;
            state_d    = MOVE;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end
      MOVE: begin
        if (move_cnt_q != 16'hFFFF) move_cnt_d = move_cnt_q + 16'd1;
`ifdef SNAKE_SPEEDUP_EN
        if (move_cnt_d[3:0] == 4'd0 && move_cnt_d != 16'd0) period_d = period_dec;
`endif
        chk_cnt_d = '0;
        state_d   = CHECK;
      end
      CHECK: begin
        if (chk_cnt_q == LAST_CHK) state_d = EVAL;
        else                       chk_cnt_d = chk_cnt_q + 1'b1;
      end
      EVAL: begin
        if (verdict != 2'b00) begin
          winner_d = verdict;
          state_d  = OVER;
        end else begin
          state_d  = RUN_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign move_en     = (state_q == MOVE);
  assign clr         = (state_q == CLEAR);
  assign running     = (state_q == RUN_WAIT) || (state_q == MOVE) ||
                       (state_q == CHECK)    || (state_q == EVAL);
  assign game_over   = (state_q == OVER);
  assign winner      = winner_q;
  assign move_cnt    = move_cnt_q;
  assign tick_period = period_q;

endmodule

// File: tb/tb_snake_round_ctrl.sv
// Bench for snake_round_ctrl: per-cycle comparison against a round-level model plus directed literal checks.
// Build with SNAKE_SPEEDUP_EN defined to exercise the period speed-up sequence.
module tb_snake_round_ctrl;

`ifdef SNAKE_SPEEDUP_EN
  localparam int TickDiv  = 40;
  localparam int TickStep = 10;
  localparam int TickMin  = 20;
`else
  localparam int TickDiv  = 4;
  localparam int TickStep = 10;
  localparam int TickMin  = 2;
`endif
  localparam int TickW    = 8;
  localparam int CheckLat = 2;
  localparam int LenW     = 4;
  localparam int WinLen   = 15;

  localparam int PhIdle  = 0;
  localparam int PhClear = 1;
  localparam int PhPlay  = 2;
  localparam int PhOver  = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start, pause, shouldStop1, shouldStop2;
  logic [LenW-1:0]  len1, len2;
  logic             moveEn, clr, running, gameOver;
  logic [1:0]       winner;
  logic [15:0]      moveCnt;
  logic [TickW-1:0] tickPeriod;

  int checks = 0;
  int errors = 0;
  logic cmpEn = 1'b0;

  // Round-level model: phase, unpaused cycles left before the next move, cycles since the last move.
  int mPhase     = PhIdle;
  int mWaitLeft  = 0;
  int mSinceMove = -1;
  int mMoves     = 0;
  int mWinner    = 0;
  int mPeriod    = TickDiv;

  snake_round_ctrl #(
    .TICK_DIV(TickDiv), .TICK_W(TickW), .CHECK_LAT(CheckLat), .max_len_bit_len(LenW),
    .WIN_LEN(WinLen), .TICK_STEP(TickStep), .TICK_MIN(TickMin)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pause(pause),
    .should_stop1(shouldStop1), .should_stop2(shouldStop2), .len1(len1), .len2(len2),
    .move_en(moveEn), .clr(clr), .running(running), .game_over(gameOver),
    .winner(winner), .move_cnt(moveCnt), .tick_period(tickPeriod)
  );

  always #5 clk = ~clk;

  function automatic int evalWinner(input logic s1, input logic s2, input int l1, input int l2);
    if (s1 || s2) return {30'd0, s1, s2};
    return {30'd0, (l2 >= WinLen), (l1 >= WinLen)};
  endfunction

  function automatic int satInc(input int m);
    return (m >= 65535) ? 65535 : m + 1;
  endfunction

  function automatic int nextPeriod(input int movesAfter, input int period);
`ifdef SNAKE_SPEEDUP_EN
    if (movesAfter != 0 && movesAfter % 16 == 0)
      return (period - TickStep < TickMin) ? TickMin : period - TickStep;
`endif
    return period;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mPhase <= PhIdle; mWaitLeft <= 0; mSinceMove <= -1;
      mMoves <= 0; mWinner <= 0; mPeriod <= TickDiv;
    end else begin
      case (mPhase)
        PhIdle, PhOver: if (start) mPhase <= PhClear;
        PhClear: begin
          mPhase <= PhPlay; mMoves <= 0; mWinner <= 0; mPeriod <= TickDiv;
          mWaitLeft <= TickDiv; mSinceMove <= -1;
        end
        default: begin
          if (mSinceMove < 0) begin
            if (!pause) begin
              if (mWaitLeft == 1) mSinceMove <= 0;
              mWaitLeft <= mWaitLeft - 1;
            end
          end else if (mSinceMove == 0) begin
            mMoves     <= satInc(mMoves);
            mPeriod    <= nextPeriod(satInc(mMoves), mPeriod);
            mSinceMove <= 1;
          end else if (mSinceMove <= CheckLat) begin
            mSinceMove <= mSinceMove + 1;
          end else if (evalWinner(shouldStop1, shouldStop2, int'(len1), int'(len2)) != 0) begin
            mWinner <= evalWinner(shouldStop1, shouldStop2, int'(len1), int'(len2));
            mPhase  <= PhOver;
          end else begin
            mSinceMove <= -1;
            mWaitLeft  <= mPeriod;
          end
        end
      endcase
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmpEn) begin
      checkOutput("model move_en",     int'(moveEn),     int'(mPhase == PhPlay && mSinceMove == 0));
      checkOutput("model clr",         int'(clr),        int'(mPhase == PhClear));
      checkOutput("model running",     int'(running),    int'(mPhase == PhPlay));
      checkOutput("model game_over",   int'(gameOver),   int'(mPhase == PhOver));
      checkOutput("model winner",      int'(winner),     mWinner);
      checkOutput("model move_cnt",    int'(moveCnt),    mMoves);
      checkOutput("model tick_period", int'(tickPeriod), mPeriod);
    end
  end

  task automatic applyStimulus(input logic st, input logic ps, input logic s1, input logic s2,
                               input int l1, input int l2, input int cycles);
    start = st; pause = ps; shouldStop1 = s1; shouldStop2 = s2;
    len1 = LenW'(l1); len2 = LenW'(l2);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic waitMove(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (moveEn) return;
    end
    checkOutput("waitMove timeout", 0, 1);
  endtask

  task automatic waitOver(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (gameOver) return;
    end
    checkOutput("waitOver timeout", 0, 1);
  endtask

  task automatic restartRound(input logic s1, input logic s2, input int l1, input int l2);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1);
    checkOutput("restart clr", int'(clr), 1);
    applyStimulus(1'b0, 1'b0, s1, s2, l1, l2, 1);
    checkOutput("restart running",  int'(running), 1);
    checkOutput("restart move_cnt", int'(moveCnt), 0);
    checkOutput("restart winner",   int'(winner),  0);
  endtask

  typedef struct {
    logic s1;
    logic s2;
    int   l1;
    int   l2;
    int   expWinner;
  } verdict_t;

  verdict_t verdicts[7] = '{
    '{1'b1, 1'b1, 0,  0,  3},
    '{1'b0, 1'b0, 0,  15, 2},
    '{1'b1, 1'b0, 15, 0,  2},
    '{1'b0, 1'b0, 15, 0,  1},
    '{1'b0, 1'b0, 15, 15, 3},
    '{1'b0, 1'b1, 0,  15, 1},
    '{1'b1, 1'b0, 0,  15, 2}
  };

  initial begin
    int n;
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2);
    cmpEn = 1'b1;
    checkOutput("reset tick_period", int'(tickPeriod), TickDiv);
    checkOutput("reset move_cnt",    int'(moveCnt),    0);
    checkOutput("reset running",     int'(running),    0);
    checkOutput("reset game_over",   int'(gameOver),   0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2);

    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1);
    checkOutput("first clr", int'(clr), 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    waitMove(n);
    checkOutput("first move delay", n, TickDiv + 1);

    // A start pulse mid-round must not disturb the move cadence.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    waitMove(n);
    checkOutput("move period", n + 2, TickDiv + CheckLat + 2);
    checkOutput("move_cnt at move 2", int'(moveCnt), 1);

`ifndef SNAKE_SPEEDUP_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 5);
    checkOutput("move_cnt before pause", int'(moveCnt), 2);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 10);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    waitMove(n);
    checkOutput("paused move delay", n, 3);

    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
    waitOver(n);
    checkOutput("over latency", n, 4);
    checkOutput("stop1 winner", int'(winner), 2);
    checkOutput("stop1 move_cnt", int'(moveCnt), 3);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 10);

    foreach (verdicts[i]) begin
      restartRound(verdicts[i].s1, verdicts[i].s2, verdicts[i].l1, verdicts[i].l2);
      waitOver(n);
      checkOutput($sformatf("verdict %0d winner", i), int'(winner), verdicts[i].expWinner);
      checkOutput($sformatf("verdict %0d move_cnt", i), int'(moveCnt), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 2);
    end
`else
    // Reach move 48 and watch the period step down and then hold at the floor.
    for (int k = 3; k <= 48; k++) begin
      waitMove(n);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1);
      if (k == 15) checkOutput("period after move 15", int'(tickPeriod), 40);
      if (k == 16) checkOutput("period after move 16", int'(tickPeriod), 30);
      if (k == 32) checkOutput("period after move 32", int'(tickPeriod), 20);
      if (k == 48) checkOutput("period after move 48", int'(tickPeriod), 20);
    end
    restartRound(1'b0, 1'b0, 0, 0);
    checkOutput("period after restart", int'(tickPeriod), 40);
`endif

    restartRound(1'b0, 1'b0, 0, 0);
    waitMove(n);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1);
    checkOutput("in check move_cnt", int'(moveCnt), 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async rst move_en",     int'(moveEn),     0);
    checkOutput("async rst clr",         int'(clr),        0);
    checkOutput("async rst running",     int'(running),    0);
    checkOutput("async rst game_over",   int'(gameOver),   0);
    checkOutput("async rst winner",      int'(winner),     0);
    checkOutput("async rst move_cnt",    int'(moveCnt),    0);
    checkOutput("async rst tick_period", int'(tickPeriod), TickDiv);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 3);
    checkOutput("idle after reset", int'(running), 0);

    cmpEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/snake_round_ctrl.md
Name: snake_round_ctrl

Overview:
- Sequencer for the two-player snake game round.
- Generates the periodic move strobe for both snake body registers and clears snakes and collision logic at round start.
- Waits for the registered collision verdicts (should_stop1/should_stop2) and the length updates to settle, then decides continue / game over / winner.
- Sits between the top-level input debouncers and the snake datapath plus collision checker.

Parameters:
- TICK_DIV, 25000000, clk cycles between moves (initial move period); must be >= 2.
- TICK_W, 25, width of tick counter and period register; must hold TICK_DIV.
- CHECK_LAT, 2, cycles waited after move_en before sampling stop flags and lengths; >= 1.
- max_len_bit_len, 4, width of len1/len2.
- WIN_LEN, 15, length at which a snake wins; < 2**max_len_bit_len.
- TICK_STEP, 1000000, period decrement per speed-up (SNAKE_SPEEDUP_EN only).
- TICK_MIN, 5000000, period floor (SNAKE_SPEEDUP_EN only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  level; begins a round from IDLE or OVER
- pause  input  1  level; freezes the move timer while high
- should_stop1  input  1  snake1 dead (from collision checker)
- should_stop2  input  1  snake2 dead
- len1  input  max_len_bit_len  snake1 length
- len2  input  max_len_bit_len  snake2 length
- move_en  output  1  one-cycle move strobe to both snakes
- clr  output  1  one-cycle clear to snakes and collision checker
- running  output  1  high in RUN_WAIT/MOVE/CHECK/EVAL
- game_over  output  1  high in OVER
- winner  output  2  00 none, 01 snake1, 10 snake2, 11 draw
- move_cnt  output  16  moves in current round, saturating at 16'hFFFF
- tick_period  output  TICK_W  current move period in cycles

Behaviour:
- Reset is asynchronous, active-low (rst_n low takes effect immediately, independent of clk). It may be asserted at any time, including mid-round.
- Reset values: state IDLE, move_en 0, clr 0, running 0, game_over 0, winner 00, move_cnt 0, tick counter 0, tick_period TICK_DIV.
- All outputs are registered or Moore-decoded from the state; no combinational path from inputs to outputs.
- States: IDLE, CLEAR, RUN_WAIT, MOVE, CHECK, EVAL, OVER.
- IDLE: start=1 -> CLEAR.
- CLEAR: clr=1 for exactly one cycle. Clears move_cnt, winner and tick counter, and reloads tick_period=TICK_DIV. Then -> RUN_WAIT.
- RUN_WAIT timer:
  - tick counter increments each cycle while pause=0 and holds while pause=1.
  - When the counter equals tick_period-1 and pause=0 -> MOVE, and the counter resets to 0.
  - First move_en therefore occurs tick_period cycles after CLEAR, excluding paused cycles.
- MOVE: move_en=1 for one cycle; move_cnt+1 (saturating). -> CHECK.
- CHECK: waits exactly CHECK_LAT cycles, then -> EVAL. Pause is ignored in MOVE/CHECK/EVAL.
- EVAL (one cycle), priority order:
  - stop1 and stop2 both set -> winner 11.
  - Only should_stop1 -> winner 10.
  - Only should_stop2 -> winner 01.
  - Otherwise len1>=WIN_LEN and len2>=WIN_LEN -> 11.
  - Otherwise len1>=WIN_LEN -> 01; len2>=WIN_LEN -> 10.
  - Any of the above -> OVER. Else -> RUN_WAIT.
  - Collision always overrides a length win in the same EVAL.
- OVER: game_over=1; winner and move_cnt hold. start=1 -> CLEAR (restart). start held high continuously after a restart is ignored until the next OVER or IDLE.
- start asserted in RUN_WAIT/MOVE/CHECK/EVAL is ignored.
- Stop flags and lengths are sampled only in EVAL; values in other states are don't-care.

Optional Feature:
- Macro: SNAKE_SPEEDUP_EN.
- Defined:
  - On each MOVE where the new move_cnt is a nonzero multiple of 16: tick_period <= max(tick_period - TICK_STEP, TICK_MIN). Computed without underflow.
  - tick_period is reset to TICK_DIV at CLEAR and at reset.
- Undefined: tick_period is constant TICK_DIV; TICK_STEP and TICK_MIN are unused.

Test Plan:
- TICK_DIV=4, CHECK_LAT=2; reset, start pulse -> clr high one cycle, then move_en pulses every 8 cycles (4 wait + 1 move + 2 check + 1 eval); move_cnt 1,2,3...; winner 00.
- Running; pause high for 10 cycles mid RUN_WAIT -> next move_en delayed by exactly 10 cycles; counter value preserved.
- should_stop1=1 before EVAL, should_stop2=0 -> game_over=1, winner=10, move_en stops; same with both set -> winner=11.
- len2=15 (WIN_LEN) and no stops -> winner=10. Then with len1=15 and should_stop1=1 -> winner=10 (collision priority).
- In OVER, start -> clr pulse, move_cnt=0, winner=00, running=1. rst_n low mid-CHECK -> all outputs at reset values immediately.
- SNAKE_SPEEDUP_EN, TICK_DIV=40, TICK_STEP=10, TICK_MIN=20 -> tick_period 40, then 30 after move 16, then 20 after move 32, and 20 after move 48.
